// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        LD_STALL = 2'd2,
        MEM_WAIT = 2'd3
    } ctrl_state_t;

    localparam int unsigned FLUSH_DEPTH_DEFAULT = 2;
    localparam int unsigned CNT_W               = 3;
    localparam int unsigned PERF_W              = 32;

    // Per-stage enable / bubble bundle driven every cycle.
    typedef struct packed {
        logic if_en;
        logic id_en;
        logic ex_en;
        logic wb_en;
        logic id_flush;
        logic ex_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTL_HOLD_ALL = '{if_en: 1'b0, id_en: 1'b0, ex_en: 1'b0, wb_en: 1'b0,
                                             id_flush: 1'b0, ex_flush: 1'b0};
    localparam stage_ctrl_t CTL_FLOW     = '{if_en: 1'b1, id_en: 1'b1, ex_en: 1'b1, wb_en: 1'b1,
                                             id_flush: 1'b0, ex_flush: 1'b0};
    localparam stage_ctrl_t CTL_BUBBLE   = '{if_en: 1'b1, id_en: 1'b1, ex_en: 1'b1, wb_en: 1'b1,
                                             id_flush: 1'b1, ex_flush: 1'b1};
    localparam stage_ctrl_t CTL_RESET    = '{if_en: 1'b0, id_en: 1'b0, ex_en: 1'b0, wb_en: 1'b0,
                                             id_flush: 1'b1, ex_flush: 1'b1};
    localparam stage_ctrl_t CTL_LD_USE   = '{if_en: 1'b0, id_en: 1'b0, ex_en: 1'b1, wb_en: 1'b1,
                                             id_flush: 1'b0, ex_flush: 1'b1};
    localparam stage_ctrl_t CTL_IMEM     = '{if_en: 1'b0, id_en: 1'b1, ex_en: 1'b1, wb_en: 1'b1,
                                             id_flush: 1'b1, ex_flush: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Flags a decode instruction that reads the destination of a load currently in exec.
module pipeline_ctrl_load_use_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             hit_c
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

    // x0 never carries a value, so a load to it cannot create a hazard.
    assign hit_c = ex_valid && ex_is_load && (ex_rd != '0) && id_valid && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables, bubble inserts, PC redirect and perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned REG_W       = 5,
    parameter int unsigned FLUSH_DEPTH = FLUSH_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_jump,
    input  logic              ex_branch_taken,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              dmem_req,
    input  logic              dmem_ack,
    input  logic              imem_ready,
    output logic              if_en,
    output logic              id_en,
    output logic              ex_en,
    output logic              wb_en,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              pc_redirect,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [1:0]        state_o,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_redirect_cnt
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_DEPTH - 1);
    localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'(1);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    stage_ctrl_t      ctl;
    logic             redirect_evt;
    logic             load_use_hit;
    logic             mem_stall;
    logic             redirect_req;

    pipeline_ctrl_load_use_detect #(
        .REG_W(REG_W)
    ) u_load_use_detect (
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .hit_c      (load_use_hit)
    );

    assign mem_stall    = ex_valid && dmem_req && !dmem_ack;
    assign redirect_req = ex_valid && (ex_jump || ex_branch_taken);

    // Next state and same-cycle control response; RUN priority is mem > load-use > redirect > imem.
    always_comb begin
        ctl          = CTL_HOLD_ALL;
        pc_redirect  = 1'b0;
        redirect_pc  = '0;
        redirect_evt = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;

        if (!rst_n) begin
            ctl       = CTL_RESET;
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        ctl       = CTL_HOLD_ALL;
                        state_nxt = MEM_WAIT;
                    end else if (load_use_hit) begin
                        ctl       = CTL_LD_USE;
                        state_nxt = LD_STALL;
                    end else if (redirect_req) begin
                        ctl          = CTL_BUBBLE;
                        pc_redirect  = 1'b1;
                        redirect_pc  = ex_target & ALIGN_MASK;
                        redirect_evt = 1'b1;
                        // A one-cycle bubble window is covered entirely by the detect cycle.
                        if (FLUSH_DEPTH > 1) begin
                            state_nxt = FLUSH;
                            cnt_nxt   = FLUSH_LOAD;
                        end
                    end else if (!imem_ready) begin
                        ctl = CTL_IMEM;
                    end else begin
                        ctl = CTL_FLOW;
                    end
                end
                FLUSH: begin
                    ctl = CTL_BUBBLE;
                    if (cnt <= CNT_W'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                LD_STALL: begin
                    ctl       = CTL_FLOW;
                    state_nxt = RUN;
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        ctl       = CTL_FLOW;
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign if_en    = ctl.if_en;
    assign id_en    = ctl.id_en;
    assign ex_en    = ctl.ex_en;
    assign wb_en    = ctl.wb_en;
    assign id_flush = ctl.id_flush;
    assign ex_flush = ctl.ex_flush;
    assign state_o  = 2'(state);

    // State, countdown and wrapping performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= RUN;
            cnt               <= '0;
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!ctl.if_en) begin
                perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
            end
            if (redirect_evt) begin
                perf_redirect_cnt <= perf_redirect_cnt + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: three instances (FLUSH_DEPTH 2, 4, 1) checked against a bubble/stall model.
module tb_pipeline_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int          N_DUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             ex_valid, ex_jump, ex_branch_taken, ex_is_load;
    logic [XLEN-1:0]  ex_target;
    logic [REG_W-1:0] ex_rd, id_rs1, id_rs2;
    logic             id_valid, id_use_rs1, id_use_rs2;
    logic             dmem_req, dmem_ack, imem_ready;

    logic [N_DUT-1:0] if_en_v, id_en_v, ex_en_v, wb_en_v, id_flush_v, ex_flush_v, pc_redirect_v;
    logic [XLEN-1:0]  redirect_pc_v [N_DUT];
    logic [1:0]       state_v       [N_DUT];
    logic [31:0]      stall_cnt_v   [N_DUT];
    logic [31:0]      redir_cnt_v   [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        pipeline_ctrl #(
            .XLEN        (XLEN),
            .REG_W       (REG_W),
            .FLUSH_DEPTH ((g == 0) ? 2 : ((g == 1) ? 4 : 1))
        ) u_dut (
            .clk               (clk),
            .rst_n             (rst_n),
            .ex_valid          (ex_valid),
            .ex_jump           (ex_jump),
            .ex_branch_taken   (ex_branch_taken),
            .ex_target         (ex_target),
            .ex_is_load        (ex_is_load),
            .ex_rd             (ex_rd),
            .id_valid          (id_valid),
            .id_rs1            (id_rs1),
            .id_rs2            (id_rs2),
            .id_use_rs1        (id_use_rs1),
            .id_use_rs2        (id_use_rs2),
            .dmem_req          (dmem_req),
            .dmem_ack          (dmem_ack),
            .imem_ready        (imem_ready),
            .if_en             (if_en_v[g]),
            .id_en             (id_en_v[g]),
            .ex_en             (ex_en_v[g]),
            .wb_en             (wb_en_v[g]),
            .id_flush          (id_flush_v[g]),
            .ex_flush          (ex_flush_v[g]),
            .pc_redirect       (pc_redirect_v[g]),
            .redirect_pc       (redirect_pc_v[g]),
            .state_o           (state_v[g]),
            .perf_stall_cnt    (stall_cnt_v[g]),
            .perf_redirect_cnt (redir_cnt_v[g])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: remaining bubble cycles, stall/wait flags and event counts.
    int         m_bub   [N_DUT];
    bit         m_ldst  [N_DUT];
    bit         m_memw  [N_DUT];
    logic [31:0] m_scnt [N_DUT];
    logic [31:0] m_rcnt [N_DUT];
    // Expected this cycle: {if,id,ex,wb,id_flush,ex_flush,pc_redirect}
    logic [6:0]  e_ctl  [N_DUT];
    logic [31:0] e_pc   [N_DUT];
    logic [1:0]  e_st   [N_DUT];
    int          e_kind [N_DUT];  // 0 none, 1 mem wait, 2 load-use, 3 redirect

    function automatic int depth_of(int g);
        return (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    endfunction

    function automatic logic [104:0] dut_obs(int g);
        return {if_en_v[g], id_en_v[g], ex_en_v[g], wb_en_v[g], id_flush_v[g], ex_flush_v[g],
                pc_redirect_v[g], redirect_pc_v[g], state_v[g], stall_cnt_v[g], redir_cnt_v[g]};
    endfunction

    function automatic logic [104:0] model_obs(int g);
        return {e_ctl[g], e_pc[g], e_st[g], m_scnt[g], m_rcnt[g]};
    endfunction

    task automatic model_eval();
        bit hz_mem, hz_lu, hz_rd;
        logic [31:0] tgt;
        hz_mem = ex_valid && dmem_req && !dmem_ack;
        hz_lu  = ex_valid && ex_is_load && (ex_rd != 0) && id_valid &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        hz_rd  = ex_valid && (ex_jump || ex_branch_taken);
        tgt    = ex_target;
        for (int g = 0; g < N_DUT; g++) begin
            e_pc[g]   = 32'h0;
            e_kind[g] = 0;
            e_st[g]   = m_memw[g] ? 2'd3 : (m_ldst[g] ? 2'd2 : ((m_bub[g] > 0) ? 2'd1 : 2'd0));
            if (!rst_n)                e_ctl[g] = 7'b0000110;
            else if (m_memw[g])        e_ctl[g] = dmem_ack ? 7'b1111000 : 7'b0000000;
            else if (m_ldst[g])        e_ctl[g] = 7'b1111000;
            else if (m_bub[g] > 0)     e_ctl[g] = 7'b1111110;
            else if (hz_mem) begin     e_ctl[g] = 7'b0000000; e_kind[g] = 1; end
            else if (hz_lu) begin      e_ctl[g] = 7'b0011010; e_kind[g] = 2; end
            else if (hz_rd) begin
                e_ctl[g]  = 7'b1111111;
                e_pc[g]   = {tgt[31:1], 1'b0};
                e_kind[g] = 3;
            end
            else if (!imem_ready)      e_ctl[g] = 7'b0111100;
            else                       e_ctl[g] = 7'b1111000;
        end
    endtask

    task automatic model_tick();
        for (int g = 0; g < N_DUT; g++) begin
            if (!rst_n) begin
                m_bub[g] = 0; m_ldst[g] = 0; m_memw[g] = 0; m_scnt[g] = 0; m_rcnt[g] = 0;
            end else begin
                if (!e_ctl[g][6]) m_scnt[g] = m_scnt[g] + 1;
                if (m_memw[g]) begin
                    if (dmem_ack) m_memw[g] = 0;
                end else if (m_ldst[g]) begin
                    m_ldst[g] = 0;
                end else if (m_bub[g] > 0) begin
                    m_bub[g] = m_bub[g] - 1;
                end else if (e_kind[g] == 1) begin
                    m_memw[g] = 1;
                end else if (e_kind[g] == 2) begin
                    m_ldst[g] = 1;
                end else if (e_kind[g] == 3) begin
                    m_bub[g]  = depth_of(g) - 1;
                    m_rcnt[g] = m_rcnt[g] + 1;
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_jump = 0; ex_branch_taken = 0; ex_target = '0; ex_is_load = 0; ex_rd = '0;
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        dmem_req = 0; dmem_ack = 0; imem_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        settle();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        ex_valid = 1; ex_jump = 1; ex_target = 32'h0000_0040; dmem_req = 0;
        rst_n = 0;
        settle();
        n_chk++;
        if ({if_en_v[0], id_en_v[0], ex_en_v[0], wb_en_v[0], id_flush_v[0], ex_flush_v[0], pc_redirect_v[0]} !== 7'b0000110
            || redirect_pc_v[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got ctl=%b pc=%h want ctl=0000110 pc=0",
                     {if_en_v[0], id_en_v[0], ex_en_v[0], wb_en_v[0], id_flush_v[0], ex_flush_v[0], pc_redirect_v[0]},
                     redirect_pc_v[0]);
        end
        tick();
        rst_n = 1;
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            settle();
            for (int g = 0; g < N_DUT; g++) begin
                n_chk++;
                if (dut_obs(g) !== model_obs(g)) begin
                    n_fail++;
                    $display("FAIL reset_idle c%0d dut%0d got=%h want=%h", c, g, dut_obs(g), model_obs(g));
                end
            end
            n_chk++;
            if (state_v[0] !== 2'd0 || stall_cnt_v[0] !== 32'd0 || redir_cnt_v[0] !== 32'd0 || if_en_v[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_flow c%0d got st=%0d sc=%0d rc=%0d if_en=%b want 0/0/0/1",
                         c, state_v[0], stall_cnt_v[0], redir_cnt_v[0], if_en_v[0]);
            end
            tick();
        end
    endtask

    task automatic test_jump();
        do_reset();
        ex_valid = 1; ex_jump = 1; ex_target = 32'h0000_0103;
        for (int c = 0; c < 5; c++) begin
            settle();
            for (int g = 0; g < N_DUT; g++) begin
                n_chk++;
                if (dut_obs(g) !== model_obs(g)) begin
                    n_fail++;
                    $display("FAIL jump c%0d dut%0d got=%h want=%h", c, g, dut_obs(g), model_obs(g));
                end
            end
            n_chk++;
            if (c == 0 && (pc_redirect_v[0] !== 1'b1 || redirect_pc_v[0] !== 32'h102)) begin
                n_fail++;
                $display("FAIL jump_redirect got pcr=%b pc=%h want 1 00000102", pc_redirect_v[0], redirect_pc_v[0]);
            end else if (c == 1 && (id_flush_v[0] !== 1'b1 || ex_flush_v[0] !== 1'b1)) begin
                n_fail++;
                $display("FAIL jump_bubble2 got %b%b want 11", id_flush_v[0], ex_flush_v[0]);
            end else if (c == 2 && (id_flush_v[0] !== 1'b0 || redir_cnt_v[0] !== 32'd1)) begin
                n_fail++;
                $display("FAIL jump_end got flush=%b rc=%0d want 0 1", id_flush_v[0], redir_cnt_v[0]);
            end
            tick();
            idle_inputs();
        end
    endtask

    task automatic test_load_use();
        for (int v = 0; v < 2; v++) begin
            do_reset();
            ex_valid = 1; ex_is_load = 1; ex_rd = (v == 0) ? 5'd5 : 5'd0;
            id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd3; id_use_rs2 = 1; id_rs2 = ex_rd;
            for (int c = 0; c < 3; c++) begin
                settle();
                for (int g = 0; g < N_DUT; g++) begin
                    n_chk++;
                    if (dut_obs(g) !== model_obs(g)) begin
                        n_fail++;
                        $display("FAIL load_use v%0d c%0d dut%0d got=%h want=%h", v, c, g, dut_obs(g), model_obs(g));
                    end
                end
                n_chk++;
                if (v == 0 && c == 0 && {if_en_v[0], id_en_v[0], ex_en_v[0], wb_en_v[0], ex_flush_v[0]} !== 5'b00111) begin
                    n_fail++;
                    $display("FAIL ld_stall_resp got=%b want=00111",
                             {if_en_v[0], id_en_v[0], ex_en_v[0], wb_en_v[0], ex_flush_v[0]});
                end else if (v == 0 && c == 1 && state_v[0] !== 2'd2) begin
                    n_fail++;
                    $display("FAIL ld_stall_state got=%0d want=2", state_v[0]);
                end else if (v == 0 && c == 2 && (state_v[0] !== 2'd0 || stall_cnt_v[0] !== 32'd1)) begin
                    n_fail++;
                    $display("FAIL ld_stall_end got st=%0d sc=%0d want 0 1", state_v[0], stall_cnt_v[0]);
                end else if (v == 1 && (if_en_v[0] !== 1'b1 || state_v[0] !== 2'd0)) begin
                    n_fail++;
                    $display("FAIL ld_x0 got if_en=%b st=%0d want 1 0", if_en_v[0], state_v[0]);
                end
                tick();
                idle_inputs();
            end
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            if (c < 4) begin ex_valid = 1; dmem_req = 1; dmem_ack = (c == 3); end
            settle();
            for (int g = 0; g < N_DUT; g++) begin
                n_chk++;
                if (dut_obs(g) !== model_obs(g)) begin
                    n_fail++;
                    $display("FAIL mem_wait c%0d dut%0d got=%h want=%h", c, g, dut_obs(g), model_obs(g));
                end
            end
            n_chk++;
            if (c < 3 && {if_en_v[0], id_en_v[0], ex_en_v[0], wb_en_v[0], id_flush_v[0], ex_flush_v[0]} !== 6'b0) begin
                n_fail++;
                $display("FAIL mem_hold c%0d got=%b want=000000", c,
                         {if_en_v[0], id_en_v[0], ex_en_v[0], wb_en_v[0], id_flush_v[0], ex_flush_v[0]});
            end else if (c == 3 && {if_en_v[0], id_en_v[0], ex_en_v[0], wb_en_v[0]} !== 4'b1111) begin
                n_fail++;
                $display("FAIL mem_ack got=%b want=1111", {if_en_v[0], id_en_v[0], ex_en_v[0], wb_en_v[0]});
            end else if (c == 4 && (stall_cnt_v[0] !== 32'd3 || state_v[0] !== 2'd0)) begin
                n_fail++;
                $display("FAIL mem_count got sc=%0d st=%0d want 3 0", stall_cnt_v[0], state_v[0]);
            end
            tick();
        end
    endtask

    task automatic test_branch_vs_load_use();
        do_reset();
        ex_valid = 1; ex_branch_taken = 1; ex_target = 32'h0000_2000; ex_is_load = 1; ex_rd = 5'd9;
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd9;
        for (int c = 0; c < 2; c++) begin
            settle();
            for (int g = 0; g < N_DUT; g++) begin
                n_chk++;
                if (dut_obs(g) !== model_obs(g)) begin
                    n_fail++;
                    $display("FAIL br_vs_lu c%0d dut%0d got=%h want=%h", c, g, dut_obs(g), model_obs(g));
                end
            end
            n_chk++;
            if (c == 0 && (pc_redirect_v[1] !== 1'b0 || ex_flush_v[1] !== 1'b1 || if_en_v[1] !== 1'b0)) begin
                n_fail++;
                $display("FAIL br_vs_lu_resp got pcr=%b exf=%b if=%b want 0 1 0", pc_redirect_v[1], ex_flush_v[1], if_en_v[1]);
            end else if (c == 1 && (state_v[1] !== 2'd2 || redir_cnt_v[1] !== 32'd0)) begin
                n_fail++;
                $display("FAIL br_vs_lu_state got st=%0d rc=%0d want 2 0", state_v[1], redir_cnt_v[1]);
            end
            tick();
            idle_inputs();
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        ex_valid = 1; ex_jump = 1; ex_target = 32'h0000_0800;
        for (int c = 0; c < 4; c++) begin
            rst_n = (c != 1);
            settle();
            for (int g = 0; g < N_DUT; g++) begin
                n_chk++;
                if (dut_obs(g) !== model_obs(g)) begin
                    n_fail++;
                    $display("FAIL rst_flush c%0d dut%0d got=%h want=%h", c, g, dut_obs(g), model_obs(g));
                end
            end
            n_chk++;
            if (c == 1 && (state_v[1] !== 2'd1 || pc_redirect_v[1] !== 1'b0)) begin
                n_fail++;
                $display("FAIL rst_in_flush got st=%0d pcr=%b want 1 0", state_v[1], pc_redirect_v[1]);
            end else if (c == 2 && (state_v[1] !== 2'd0 || id_flush_v[1] !== 1'b0 || ex_flush_v[1] !== 1'b0
                                    || stall_cnt_v[1] !== 32'd0 || redir_cnt_v[1] !== 32'd0)) begin
                n_fail++;
                $display("FAIL rst_release got st=%0d fl=%b%b sc=%0d rc=%0d want 0 00 0 0",
                         state_v[1], id_flush_v[1], ex_flush_v[1], stall_cnt_v[1], redir_cnt_v[1]);
            end
            tick();
            idle_inputs();
        end
        rst_n = 1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            ex_valid        = ($urandom_range(0, 3) != 0);
            ex_jump         = ($urandom_range(0, 7) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_target       = $urandom();
            ex_is_load      = ($urandom_range(0, 2) == 0);
            ex_rd           = 5'($urandom_range(0, 3));
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_use_rs1      = ($urandom_range(0, 1) != 0);
            id_use_rs2      = ($urandom_range(0, 1) != 0);
            dmem_req        = ($urandom_range(0, 4) == 0);
            dmem_ack        = ($urandom_range(0, 2) == 0);
            imem_ready      = ($urandom_range(0, 4) != 0);
            if (dmem_req) begin ex_jump = 0; ex_branch_taken = 0; end
            rst_n           = ($urandom_range(0, 49) != 0);
            settle();
            for (int g = 0; g < N_DUT; g++) begin
                n_chk++;
                if (dut_obs(g) !== model_obs(g)) begin
                    n_fail++;
                    $display("FAIL random c%0d dut%0d got=%h want=%h", c, g, dut_obs(g), model_obs(g));
                end
            end
            tick();
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        idle_inputs();
        for (int g = 0; g < N_DUT; g++) begin
            m_bub[g] = 0; m_ldst[g] = 0; m_memw[g] = 0; m_scnt[g] = 0; m_rcnt[g] = 0;
            e_ctl[g] = '0; e_pc[g] = '0; e_st[g] = '0; e_kind[g] = 0;
        end
        #1;
        test_reset();
        test_jump();
        test_load_use();
        test_mem_wait();
        test_branch_vs_load_use();
        test_reset_mid_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencer for the RV32I core. Sits beside the fetch, decode, exec and writeback stages. Consumes the exec stage's jump/taken-branch indications, load/register information from exec and decode, and the data-memory handshake. Drives per-stage enables, bubble-insert (flush) controls, the PC redirect, and two performance counters.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- REG_W, 5, register index width
- FLUSH_DEPTH, 2, bubble cycles inserted after a redirect (legal range 1..7)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  exec stage holds a real instruction
- ex_jump  in  1  exec instruction is JAL/JALR
- ex_branch_taken  in  1  exec branch condition resolved true
- ex_target  in  XLEN  jump/branch target computed by exec
- ex_is_load  in  1  exec instruction is a load
- ex_rd  in  REG_W  exec destination register
- id_valid  in  1  decode stage holds a real instruction
- id_rs1, id_rs2  in  REG_W  decode source registers
- id_use_rs1, id_use_rs2  in  1  decode instruction reads rs1/rs2
- dmem_req  in  1  exec/dmem instruction has an outstanding memory access
- dmem_ack  in  1  data memory completes the access this cycle
- imem_ready  in  1  instruction memory returns a valid word this cycle
- if_en, id_en, ex_en, wb_en  out  1  stage register load enables
- id_flush, ex_flush  out  1  load a bubble into ID/EX at the next edge
- pc_redirect  out  1  PC loads redirect_pc at the next edge
- redirect_pc  out  XLEN  new PC
- state_o  out  2  current state (debug)
- perf_stall_cnt  out  32  cycles with if_en=0
- perf_redirect_cnt  out  32  redirects taken

## Operation
- States: RUN, FLUSH, LD_STALL, MEM_WAIT. Reset state is RUN.
- While rst_n=0:
  - Enables = 0; id_flush = ex_flush = 1; pc_redirect = 0; redirect_pc = 0.
  - Counters cleared.
  - FLUSH countdown cleared.
- Event priority in RUN (highest first): mem wait > load-use > redirect > imem stall.
- MEM_WAIT:
  - Entry: ex_valid & dmem_req & !dmem_ack.
  - All four enables = 0 and no flushes while in this state.
  - Exit to RUN on the cycle dmem_ack=1; that cycle all enables = 1.
  - dmem_req & dmem_ack in the same cycle: no state change.
- Load-use:
  - Condition: ex_valid & ex_is_load & ex_rd≠0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: if_en = id_en = 0, ex_flush = 1, ex_en = wb_en = 1; go to LD_STALL.
  - LD_STALL lasts exactly one cycle with all enables = 1 and no flush, then RUN.
- Redirect:
  - Condition: ex_valid & (ex_jump | ex_branch_taken).
  - Response: pc_redirect = 1, redirect_pc = ex_target with bit 0 cleared, id_flush = ex_flush = 1 in the same cycle.
  - Next state FLUSH with countdown = FLUSH_DEPTH−1; perf_redirect_cnt += 1.
- FLUSH:
  - id_flush = ex_flush = 1; all enables = 1; ex_* inputs ignored.
  - Countdown decrements each cycle; at 0 go to RUN.
  - FLUSH_DEPTH=1 means FLUSH is skipped (go directly to RUN).
- imem_ready=0 in RUN with no higher event: if_en = 0, id_flush = 1, no state change.
- Counters: 32-bit, wrap from 0xFFFF_FFFF to 0. Not incremented while rst_n=0.
- ex_jump | ex_branch_taken together with dmem_req is illegal; mem wait wins.

## Timing
- Control outputs are combinational from state plus inputs (same-cycle response). State, countdown and counters are registered on the rising edge of clk.
- Redirect-to-first-correct-path-fetch latency: 1 cycle. Bubble window: FLUSH_DEPTH cycles, including the detect cycle.
- Reset asserted mid-FLUSH, LD_STALL or MEM_WAIT: at the next edge the state is RUN and the countdown is 0; no redirect is emitted.
- Counters are visible one cycle after the counted cycle.

## Structure
- defs package: ctrl_state_t enum (RUN, FLUSH, LD_STALL, MEM_WAIT) and the default FLUSH_DEPTH constant.
- Sub-module load_use_detect: purely combinational comparator producing the load-use hit.
- The FSM, countdown and counters live in pipeline_ctrl.

## Test plan
- Reset release, idle flow: all enables = 1, flushes = 0, state_o = RUN, both counters stay 0 over 10 cycles.
- JAL in exec with ex_target=0x0000_0103 → pc_redirect = 1 and redirect_pc = 0x102 in the same cycle; id_flush/ex_flush high for 2 cycles; perf_redirect_cnt = 1.
- Load to x5 in exec with decode reading rs2=x5 → 1-cycle stall: if_en = id_en = 0 and ex_flush = 1; next cycle LD_STALL; then RUN; perf_stall_cnt = 1. The same stimulus with ex_rd = x0 → no stall.
- dmem_req held with ack arriving after 3 cycles → all enables = 0 for 3 cycles, resume on the ack cycle; perf_stall_cnt = 3.
- Taken branch and load-use presented together → load-use response wins; no redirect.
- rst_n low for 1 cycle during FLUSH (FLUSH_DEPTH = 4, second bubble) → after release state_o = RUN, flushes = 0, counters = 0.
